// File: rtl/cvxif_result_buffer_pkg.sv
// Shared types for the CV-X-IF result buffer.
// Holds the result payload layout that travels from the coprocessor to the CPU.
// The buffer treats the payload as opaque; only its width matters here.
package cvxif_result_buffer_pkg;

  localparam int unsigned XLen        = 32;
  localparam int unsigned X_ID_WIDTH  = 4;
  localparam int unsigned X_RFW_WIDTH = XLen;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFW_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic                   we;
    logic                   exc;
    logic [5:0]             exccode;
  } x_result_t;

endpackage

// File: rtl/cvxif_result_buffer_fifo.sv
// Result storage FIFO.
// Ports:
//   clk_i/rst_ni  clock, async active-low reset
//   push_i/data_i write side (ignored while full)
//   pop_i/data_o  read side (ignored while empty)
//   full_o/empty_o/usage_o  fill status
// With FallThrough set, a push into an empty FIFO is visible on data_o in the
// same cycle; if it is also popped that cycle nothing is stored.
module cvxif_result_buffer_fifo #(
  parameter bit          FallThrough = 1'b0,
  parameter int unsigned Depth       = 4,
  parameter type         data_t      = logic
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  data_t                  data_i,
  input  logic                   pop_i,
  output data_t                  data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] usage_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [PtrW:0]   cnt_t;

  data_t mem_q [Depth];
  ptr_t  rd_ptr_q, rd_ptr_d;
  ptr_t  wr_ptr_q, wr_ptr_d;
  cnt_t  cnt_q, cnt_d;
  logic  wr_en;
  logic  fwd;

  assign fwd     = FallThrough && (cnt_q == '0) && push_i;
  assign full_o  = (cnt_q == cnt_t'(Depth));
  assign empty_o = (cnt_q == '0) && !fwd;
  assign usage_o = cnt_q;
  assign data_o  = fwd ? data_i : mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    wr_en    = 1'b0;
    if (push_i && !full_o) begin
      wr_en    = 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;  // power-of-two depth: natural wrap
      cnt_d    = cnt_d + 1'b1;
    end
    if (pop_i && !empty_o) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_d    = cnt_d - 1'b1;
    end
    // Forwarded and consumed in the same cycle: leave storage untouched.
    if (fwd && pop_i) begin
      wr_en    = 1'b0;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      if (wr_en) mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/cvxif_result_buffer.sv
// CV-X-IF result buffer between the coprocessor result port and the CPU.
// Ports:
//   issue_fire_i / issue_allow_o  credit handshake with the issue stage
//   res_valid_i / res_ready_o / res_i  coprocessor result input
//   x_result_valid_o / x_result_ready_i / x_result_o  CPU result output
//   occupancy_o  stored entries, outstanding_o  issued-but-not-popped results
//   overflow_o   sticky: a result arrived while the buffer was full
// Issue credits are capped at Depth, so a well-behaved coprocessor can never
// overrun the storage even while the CPU withholds x_result_ready_i.
module cvxif_result_buffer
  import cvxif_result_buffer_pkg::*;
#(
  parameter int unsigned Depth       = 4,
  parameter bit          FallThrough = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   issue_fire_i,
  output logic                   issue_allow_o,
  input  logic                   res_valid_i,
  output logic                   res_ready_o,
  input  x_result_t              res_i,
  output logic                   x_result_valid_o,
  input  logic                   x_result_ready_i,
  output x_result_t              x_result_o,
  output logic [$clog2(Depth):0] occupancy_o,
  output logic [$clog2(Depth):0] outstanding_o,
  output logic                   overflow_o
);

  typedef logic [$clog2(Depth):0] cnt_t;
  localparam cnt_t DepthCnt = cnt_t'(Depth);

  logic      fifo_full, fifo_empty;
  logic      push, pop;
  x_result_t fifo_data;
  cnt_t      outstanding_q, outstanding_d;
  logic      overflow_q, overflow_d;

  cvxif_result_buffer_fifo #(
    .FallThrough(FallThrough),
    .Depth      (Depth),
    .data_t     (x_result_t)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push),
    .data_i (res_i),
    .pop_i  (pop),
    .data_o (fifo_data),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .usage_o(occupancy_o)
  );

  assign res_ready_o      = !fifo_full;
  assign push             = res_valid_i && res_ready_o;
  assign x_result_valid_o = !fifo_empty;
  assign pop              = x_result_valid_o && x_result_ready_i;
  // Stale storage is never exposed toward the CPU.
  assign x_result_o       = x_result_valid_o ? fifo_data : '0;
  assign issue_allow_o    = (outstanding_q < DepthCnt);
  assign outstanding_o    = outstanding_q;
  assign overflow_o       = overflow_q;

  always_comb begin
    outstanding_d = outstanding_q;
    if (issue_fire_i && !pop) begin
      if (outstanding_q != DepthCnt) outstanding_d = outstanding_q + 1'b1;
    end else if (pop && !issue_fire_i) begin
      if (outstanding_q != '0) outstanding_d = outstanding_q - 1'b1;
    end
    overflow_d = overflow_q | (res_valid_i && fifo_full);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      overflow_q    <= overflow_d;
    end
  end

  a_issue_when_no_credit: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(issue_fire_i && (outstanding_q == DepthCnt)));
  a_pop_without_credit: assert property (@(posedge clk_i) disable iff (!rst_ni)
    pop |-> (outstanding_q != '0));
  a_occupancy_le_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (occupancy_o <= outstanding_q) && (outstanding_q <= DepthCnt));

endmodule

// File: tb/tb_cvxif_result_buffer.sv
module tb_cvxif_result_buffer;
  import cvxif_result_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // a_*: registered-latency instance, b_*: fall-through instance
  logic      a_fire, a_allow, a_rv, a_rready, a_xvalid, a_rdy, a_ovf;
  x_result_t a_res, a_xres;
  logic [2:0] a_occ, a_out;
  logic      b_fire, b_allow, b_rv, b_rready, b_xvalid, b_rdy, b_ovf;
  x_result_t b_res, b_xres;
  logic [2:0] b_occ, b_out;

  cvxif_result_buffer #(.Depth(4), .FallThrough(1'b0)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .issue_fire_i(a_fire), .issue_allow_o(a_allow),
    .res_valid_i(a_rv), .res_ready_o(a_rready), .res_i(a_res),
    .x_result_valid_o(a_xvalid), .x_result_ready_i(a_rdy), .x_result_o(a_xres),
    .occupancy_o(a_occ), .outstanding_o(a_out), .overflow_o(a_ovf)
  );

  cvxif_result_buffer #(.Depth(4), .FallThrough(1'b1)) u_dut_ft (
    .clk_i(clk), .rst_ni(rst_n),
    .issue_fire_i(b_fire), .issue_allow_o(b_allow),
    .res_valid_i(b_rv), .res_ready_o(b_rready), .res_i(b_res),
    .x_result_valid_o(b_xvalid), .x_result_ready_i(b_rdy), .x_result_o(b_xres),
    .occupancy_o(b_occ), .outstanding_o(b_out), .overflow_o(b_ovf)
  );

  function automatic x_result_t mk(input logic [3:0] id, input logic [31:0] data);
    x_result_t r;
    r.id      = id;
    r.data    = data;
    r.rd      = {1'b1, id};
    r.we      = 1'b1;
    r.exc     = id[0];
    r.exccode = {2'b10, id};
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    a_fire = 1'b0; a_rv = 1'b0; a_rdy = 1'b0; a_res = '0;
    b_fire = 1'b0; b_rv = 1'b0; b_rdy = 1'b0; b_res = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_valid", 64'(a_xvalid), 64'd0);
    check("rst_xres", 64'(a_xres), 64'd0);
    check("rst_occ", 64'(a_occ), 64'd0);
    check("rst_out", 64'(a_out), 64'd0);
    check("rst_ovf", 64'(a_ovf), 64'd0);
    check("rst_allow", 64'(a_allow), 64'd1);
    check("rst_rready", 64'(a_rready), 64'd1);
    check("rst_ft_valid", 64'(b_xvalid), 64'd0);
    check("rst_ft_allow", 64'(b_allow), 64'd1);
    #19 rst_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_allow", 64'(a_allow), 64'd1);
      check("idle_rready", 64'(a_rready), 64'd1);
      check("idle_xres", 64'(a_xres), 64'd0);
      check("idle_valid", 64'(a_xvalid), 64'd0);
    end

    // Single result, one-cycle latency
    a_fire = 1'b1; tick(); a_fire = 1'b0;
    check("t2_out1", 64'(a_out), 64'd1);
    a_rdy = 1'b1; a_rv = 1'b1; a_res = mk(4'd3, 32'hDEAD);
    #1;
    check("t2_no_same_cycle", 64'(a_xvalid), 64'd0);
    tick(); a_rv = 1'b0; a_res = '0; #1;
    check("t2_valid", 64'(a_xvalid), 64'd1);
    check("t2_xres", 64'(a_xres), 64'(mk(4'd3, 32'hDEAD)));
    check("t2_occ1", 64'(a_occ), 64'd1);
    tick();
    check("t2_occ0", 64'(a_occ), 64'd0);
    check("t2_valid0", 64'(a_xvalid), 64'd0);
    check("t2_out0", 64'(a_out), 64'd0);
    a_rdy = 1'b0;

    // Fill under backpressure, then drain in order
    a_fire = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_allow", 64'(a_allow), (i < 3) ? 64'd1 : 64'd0);
    end
    a_fire = 1'b0;
    check("t3_out4", 64'(a_out), 64'd4);
    for (int i = 0; i < 4; i++) begin
      a_rv = 1'b1; a_res = mk(4'(i), 32'(32'h100 + i));
      tick();
      check("t3_occ", 64'(a_occ), 64'(i + 1));
    end
    a_rv = 1'b0; a_res = '0;
    check("t3_rready_full", 64'(a_rready), 64'd0);
    check("t3_head", 64'(a_xres), 64'(mk(4'd0, 32'h100)));
    tick();
    check("t3_head_stable", 64'(a_xres), 64'(mk(4'd0, 32'h100)));
    check("t3_valid_held", 64'(a_xvalid), 64'd1);
    a_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t3_order", 64'(a_xres), 64'(mk(4'(i), 32'(32'h100 + i))));
      if (i == 0) check("t3_allow_before_pop", 64'(a_allow), 64'd0);
      if (i == 1) check("t3_allow_after_pop", 64'(a_allow), 64'd1);
      tick();
    end
    check("t3_valid_end", 64'(a_xvalid), 64'd0);
    check("t3_occ_end", 64'(a_occ), 64'd0);
    check("t3_out_end", 64'(a_out), 64'd0);
    check("t3_xres_end", 64'(a_xres), 64'd0);
    a_rdy = 1'b0;

    // Steady push+pop at occupancy 2 across pointer wrap
    a_fire = 1'b1; a_rv = 1'b1; a_res = mk(4'd0, 32'h200);
    tick();
    a_res = mk(4'd1, 32'h201);
    tick();
    check("t4_occ2", 64'(a_occ), 64'd2);
    check("t4_out2", 64'(a_out), 64'd2);
    a_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      a_res = mk(4'(k + 2), 32'(32'h200 + k + 2));
      #1;
      check("t4_head", 64'(a_xres), 64'(mk(4'(k), 32'(32'h200 + k))));
      tick();
      check("t4_occ", 64'(a_occ), 64'd2);
      check("t4_out", 64'(a_out), 64'd2);
    end
    a_fire = 1'b0; a_rv = 1'b0; a_res = '0;
    check("t4_no_ovf", 64'(a_ovf), 64'd0);
    for (int k = 8; k < 10; k++) begin
      check("t4_tail", 64'(a_xres), 64'(mk(4'(k), 32'(32'h200 + k))));
      tick();
    end
    check("t4_occ0", 64'(a_occ), 64'd0);
    check("t4_out0", 64'(a_out), 64'd0);
    a_rdy = 1'b0;

    // Fall-through: forwarded in the same cycle, nothing stored
    b_fire = 1'b1; tick(); b_fire = 1'b0;
    b_rdy = 1'b1; b_rv = 1'b1; b_res = mk(4'd7, 32'hCAFE);
    #1;
    check("t5_valid", 64'(b_xvalid), 64'd1);
    check("t5_xres", 64'(b_xres), 64'(mk(4'd7, 32'hCAFE)));
    check("t5_occ", 64'(b_occ), 64'd0);
    check("t5_rready", 64'(b_rready), 64'd1);
    tick(); b_rv = 1'b0; b_res = '0; #1;
    check("t5_occ_after", 64'(b_occ), 64'd0);
    check("t5_valid_after", 64'(b_xvalid), 64'd0);
    check("t5_out_after", 64'(b_out), 64'd0);
    check("t5_xres_after", 64'(b_xres), 64'd0);
    b_rdy = 1'b0;

    // Overflow, then reset mid-drain
    a_fire = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    a_fire = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_rv = 1'b1; a_res = mk(4'(10 + i), 32'(32'h300 + i));
      tick();
    end
    a_res = mk(4'd14, 32'h3FF);
    #1;
    check("t6_rready", 64'(a_rready), 64'd0);
    tick(); a_rv = 1'b0; a_res = '0;
    check("t6_ovf", 64'(a_ovf), 64'd1);
    check("t6_occ", 64'(a_occ), 64'd4);
    check("t6_head", 64'(a_xres), 64'(mk(4'd10, 32'h300)));
    tick();
    check("t6_ovf_sticky", 64'(a_ovf), 64'd1);
    a_rdy = 1'b1;
    tick();
    check("t6_head_next", 64'(a_xres), 64'(mk(4'd11, 32'h301)));
    check("t6_occ3", 64'(a_occ), 64'd3);
    check("t6_out3", 64'(a_out), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(a_xvalid), 64'd0);
    check("t6_rst_xres", 64'(a_xres), 64'd0);
    check("t6_rst_occ", 64'(a_occ), 64'd0);
    check("t6_rst_out", 64'(a_out), 64'd0);
    check("t6_rst_ovf", 64'(a_ovf), 64'd0);
    check("t6_rst_allow", 64'(a_allow), 64'd1);
    check("t6_rst_rready", 64'(a_rready), 64'd1);
    a_rdy = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    check("t6_post_valid", 64'(a_xvalid), 64'd0);
    check("t6_post_ovf", 64'(a_ovf), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cvxif_result_buffer.md
Name: cvxif_result_buffer

Overview:
- Sits directly downstream of the example coprocessor on the CV-X-IF result path, between the coprocessor result output and the CPU result interface.
- Buffers up to Depth results and honours CPU backpressure on x_result_ready, so the coprocessor no longer needs x_result_ready to be stuck high.
- Tracks outstanding result-producing instructions with a credit counter and gates issue acceptance so the buffer can never overflow.

Parameters:
CVA6Cfg, config_pkg::cva6_cfg_empty, CVA6 configuration (XLEN, X-IF widths)
Depth, 4, number of result entries; power of two, >= 2
FallThrough, 1'b0, 1: an empty buffer forwards a push combinationally to the output in the same cycle; 0: one-cycle registered latency

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active low
issue_fire_i  in  1  one pulse per accepted issue that will produce a result
issue_allow_o  out  1  coprocessor may accept a new issue (AND-ed into its x_issue_ready)
res_valid_i  in  1  coprocessor result valid
res_ready_o  out  1  buffer can take a result
res_i  in  x_result_t  coprocessor result (id, data, rd, we, exc, exccode)
x_result_valid_o  out  1  result valid toward CPU
x_result_ready_i  in  1  CPU accepts result
x_result_o  out  x_result_t  head result toward CPU
occupancy_o  out  $clog2(Depth)+1  entries currently stored
outstanding_o  out  $clog2(Depth)+1  issued but not yet popped results
overflow_o  out  1  sticky error: push while full

Behaviour:
- Reset (async, rst_ni low): buffer empty, pointers 0, occupancy_o = 0, outstanding_o = 0, x_result_valid_o = 0, x_result_o = '0, res_ready_o = 1, issue_allow_o = 1, overflow_o = 0. Stored entries are discarded. Reset mid-operation drops everything with no partial output.
- push = res_valid_i && res_ready_o.
- pop = x_result_valid_o && x_result_ready_i.
- res_ready_o = (occupancy_o != Depth).
- FIFO order is strict; results leave in arrival order.
- FallThrough=0:
  - x_result_valid_o = (occupancy_o != 0), registered.
  - A push into an empty buffer appears on x_result_o the next cycle. Latency is 1 cycle.
- FallThrough=1:
  - When empty and push, x_result_valid_o = 1 and x_result_o = res_i in the same cycle.
  - If pop also occurs in that cycle, nothing is stored and occupancy is unchanged.
- x_result_o presents the head entry when valid and '0 when empty. It must stay stable while x_result_valid_o && !x_result_ready_i.
- Simultaneous push and pop when not empty: occupancy is unchanged and both pointers advance.
- Push and pop when full: res_ready_o = 0, so no push happens; the pop proceeds.
- Pointers wrap modulo Depth.
- Credit counter:
  - outstanding increments on issue_fire_i and decrements on pop.
  - Both in the same cycle: no change.
  - issue_allow_o = (outstanding_o < Depth), combinational from the registered count.
  - Invariant: occupancy_o <= outstanding_o <= Depth.
- issue_fire_i while outstanding_o == Depth is illegal. The counter saturates at Depth and an SVA assertion fires.
- Pop decrementing outstanding at 0 is impossible by construction and is asserted.
- overflow_o: set if res_valid_i && occupancy_o == Depth. Stays set until reset. The dropped result is not stored.
- Bits of x_result_t are passed through unmodified. The buffer never inspects id or we.

Decomposition:
- x_result_t, X_ID_WIDTH and X_RFW_WIDTH stay in cvxif_pkg.
- Add a localparam-derived count type (logic [$clog2(Depth):0]) locally. No new package entries are required.
- Storage is one sub-module: fifo_v3 from common_cells, with DATA_T = x_result_t, DEPTH = Depth, FALL_THROUGH = FallThrough.
- The credit counter, overflow flag and the output zeroing are in the top module.

Test Plan:
- Reset then idle: all outputs at reset values; issue_allow_o=1, res_ready_o=1, x_result_o=0 for 10 cycles.
- FallThrough=0, ready=1, push id=3 data=0xDEAD: x_result_valid_o=1 with id=3 data=0xDEAD exactly 1 cycle later; occupancy returns to 0 after the pop.
- ready=0, 4 issue_fire pulses then 4 pushes (id 0..3): issue_allow_o=0 after the 4th fire; res_ready_o=0 at occupancy 4. Then ready=1: ids pop in order 0,1,2,3, one per cycle; issue_allow_o reasserts the cycle after the first pop.
- Simultaneous push and pop at occupancy 2 for 8 cycles: occupancy_o stays 2, ids stay in order across pointer wrap, no overflow_o.
- FallThrough=1, empty, push id=7 with ready=1: valid and id=7 in the same cycle; occupancy_o stays 0.
- Force res_valid_i at occupancy 4: overflow_o=1 and sticky, stored entries unchanged. Assert rst_ni mid-drain: all outputs return to reset values immediately (asynchronously).
